// File: rtl/hamming_8_4_encoder_if.sv
// rtl/hamming_8_4_encoder_if.sv - input nibble stream and output codeword stream of the Hamming(8,4) encoder
interface hamming_8_4_encoder_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_code;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_valid
  );
endinterface

// File: rtl/hamming_8_4_encoder.sv
// rtl/hamming_8_4_encoder.sv - streaming SECDED Hamming(8,4) encoder with output FIFO
// Optional error injection compiled in by defining HAMMING_ERR_INJECT_EN.
module hamming_8_4_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_8_4_encoder_if.slave  s,
  input  logic                  inj_en_i,
  input  logic                  inj_double_i,
  input  logic [2:0]            inj_pos_a_i,
  input  logic [2:0]            inj_pos_b_i,
  output logic [7:0]            tx_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  tx_count_q, tx_count_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  code_clean;
  logic [7:0]  code_stored;
  logic        full, empty, push, pop;

  // Bit layout matches the downstream decoder: c0 overall parity, c1/c2/c4 check bits.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    c[0] = ^c[7:1];
    return c;
  endfunction

  assign code_clean = encode(s.in_data);

`ifdef HAMMING_ERR_INJECT_EN
  logic [7:0] inj_mask;

  // XOR-ing the second flip makes equal positions cancel out.
  always_comb begin
    inj_mask = '0;
    if (inj_en_i) begin
      inj_mask[inj_pos_a_i] = 1'b1;
      if (inj_double_i) begin
        inj_mask[inj_pos_b_i] = inj_mask[inj_pos_b_i] ^ 1'b1;
      end
    end
  end

  assign code_stored = code_clean ^ inj_mask;
`else
  logic unused_inj;

  assign unused_inj  = ^{inj_en_i, inj_double_i, inj_pos_a_i, inj_pos_b_i};
  assign code_stored = code_clean;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = s.in_valid && !full;
  assign pop   = !empty && s.out_ready;

  assign s.in_ready  = !full;
  assign s.out_valid = !empty;
  assign s.out_code  = mem_q[rd_ptr_q[AW-1:0]];
  assign tx_count_o  = tx_count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_count_d = tx_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
      tx_count_d = tx_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_count_q <= tx_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= code_stored;
    end
  end
endmodule

// File: tb/tb_hamming_8_4_encoder.sv
// tb/tb_hamming_8_4_encoder.sv - directed and round-trip checks for hamming_8_4_encoder
module tb_hamming_8_4_encoder;
  logic       clk;
  logic       rst_n;
  logic       inj_en, inj_double;
  logic [2:0] inj_pos_a, inj_pos_b;
  logic [7:0] tx_count;
  int         n_checks;
  int         n_errors;
  logic [7:0] code_tab [16];
  logic [3:0] nib;

  hamming_8_4_encoder_if bus ();

  hamming_8_4_encoder #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (bus),
    .inj_en_i     (inj_en),
    .inj_double_i (inj_double),
    .inj_pos_a_i  (inj_pos_a),
    .inj_pos_b_i  (inj_pos_b),
    .tx_count_o   (tx_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent decoder: {syndrome[2:0], overall parity, data[3:0]}
  function automatic logic [7:0] decode(input logic [7:0] c);
    logic [2:0] syn;
    syn[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
    syn[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
    syn[2] = c[4] ^ c[5] ^ c[6] ^ c[7];
    return {syn, ^c, c[7], c[6], c[5], c[3]};
  endfunction

  task automatic push_one(input string tag, input logic [3:0] d, input logic [7:0] exp);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    inj_en       = 1'b0;
    inj_double   = 1'b0;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_code"}, 32'(bus.out_code), 32'(exp));
    step();
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    code_tab = '{8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69,
                 8'h96, 8'h99, 8'hA5, 8'hAA, 8'hC3, 8'hCC, 8'hF0, 8'hFF};
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    inj_en        = 1'b0;
    inj_double    = 1'b0;
    inj_pos_a     = '0;
    inj_pos_b     = '0;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_out_code", 32'(bus.out_code), 32'h00);
    rst_n = 1'b1;
    step();

    bus.out_ready = 1'b1;
    push_one("enc_b", 4'b1011, 8'hAA);
    push_one("enc_0", 4'h0, 8'h00);
    push_one("enc_f", 4'hF, 8'hFF);
    chk("tx_after_3", 32'(tx_count), 32'd3);

    inj_en = 1'b1; inj_pos_a = 3'd2;
`ifdef HAMMING_ERR_INJECT_EN
    push_one("inj_single", 4'b1011, 8'hAE);
`else
    push_one("inj_single", 4'b1011, 8'hAA);
`endif
    inj_en = 1'b1; inj_double = 1'b1; inj_pos_a = 3'd2; inj_pos_b = 3'd5;
`ifdef HAMMING_ERR_INJECT_EN
    push_one("inj_double", 4'b1011, 8'h8E);
`else
    push_one("inj_double", 4'b1011, 8'hAA);
`endif
    inj_en = 1'b1; inj_double = 1'b1; inj_pos_a = 3'd5; inj_pos_b = 3'd5;
    push_one("inj_cancel", 4'b1011, 8'hAA);
    chk("tx_after_6", 32'(tx_count), 32'd6);

    // Backpressure: third nibble must be held while full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h1;
    step();
    chk("bp_ready_1", 32'(bus.in_ready), 32'd1);
    bus.in_data = 4'h2;
    step();
    chk("bp_full", 32'(bus.in_ready), 32'd0);
    bus.in_data = 4'h3;
    step();
    chk("bp_held_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_stable", 32'(bus.out_code), 32'h0F);
    bus.out_ready = 1'b1;
    step();
    chk("bp_pop1_code", 32'(bus.out_code), 32'h33);
    chk("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_pushpop_code", 32'(bus.out_code), 32'h3C);
    chk("bp_pushpop_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_pushpop_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);
    chk("tx_after_9", 32'(tx_count), 32'd9);

    // Mid-stream asynchronous reset with one buffered word
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h5;
    step();
    bus.in_valid = 1'b0;
    chk("mr_buffered", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_tx_count", 32'(tx_count), 32'd0);
    chk("mr_out_code", 32'(bus.out_code), 32'h00);
    step();
    rst_n = 1'b1;
    step();

    // 257 back-to-back handshakes at full throughput
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.in_data = 4'(i);
      step();
      chk("thru_code", 32'(bus.out_code), 32'(code_tab[i % 16]));
      chk("thru_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("wrap_tx_count", 32'(tx_count), 32'd1);

    // Random round-trip through the reference decoder
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      nib         = 4'($urandom_range(0, 15));
      bus.in_data = nib;
      step();
      chk("rt_decode", 32'(decode(bus.out_code)), {24'd0, 4'd0, nib});
    end
    bus.in_valid = 1'b0;
    step();
    chk("rt_tx_count", 32'(tx_count), 32'd233);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hamming_8_4_encoder.md
# hamming_8_4_encoder

Streaming extended Hamming(8,4) SECDED encoder that sits directly upstream of the 8,4 decoder. It accepts 4-bit data nibbles over a valid/ready handshake and encodes each into an 8-bit codeword whose bit positions match the decoder: bit 0 is overall parity, bits 1/2/4 are Hamming parity, and bits 3/5/6/7 carry data. Codewords are buffered in a small FIFO and presented downstream over a second valid/ready handshake. An optional error-injection path lets the bench corrupt codewords on purpose to exercise the decoder.

## Interface
- FIFO_DEPTH, 2, number of buffered codewords; must be a power of 2 and ≥2.
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  4  data nibble; in_data[0..3] map to codeword bits 3, 5, 6, 7.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  encoder can accept a nibble; equals not-full.
- out_code  output  8  codeword at the FIFO head.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  downstream accepts out_code.
- inj_en  input  1  corrupt the codeword being pushed this cycle.
- inj_double  input  1  when high, also flip inj_pos_b.
- inj_pos_a  input  3  first bit position to flip.
- inj_pos_b  input  3  second bit position to flip.
- tx_count  output  8  number of completed output handshakes; wraps modulo 256.

## Operation
- Encoding, with c[i] denoting codeword bit i:
  - c3=d0, c5=d1, c6=d2, c7=d3.
  - c1=c3^c5^c7, c2=c3^c6^c7, c4=c5^c6^c7.
  - c0 = XOR of c1..c7.
  - Result: every valid codeword has syndrome 0 and even overall parity.
- Push: occurs when in_valid && in_ready. The encoded word, after injection, is written at wr_ptr and wr_ptr advances.
- Pop: occurs when out_valid && out_ready. rd_ptr advances and tx_count increments.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- When full, in_ready=0 and upstream must hold its data. There is no combinational pass-through from in to out.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and use natural wrap.
  - empty = pointers equal.
  - full = MSBs differ and remaining bits equal.
- out_code = storage[rd_ptr]. It is held stable while out_valid && !out_ready.
- Injection is evaluated at push time only, so stored words never change after they are written.
  - With inj_en=1, bit inj_pos_a is flipped.
  - If inj_double=1 as well, bit inj_pos_b is also flipped.
  - If inj_pos_a == inj_pos_b, the two flips cancel and the word is stored uncorrupted.
  - Injection inputs are ignored on cycles with no push.

## Timing
- Reset values (asynchronous): out_valid=0, in_ready=1, tx_count=0, all storage=8'h00, out_code=8'h00, both pointers=0.
- Latency: a nibble pushed at edge N, into an empty FIFO, gives out_valid=1 and the correct out_code after edge N.
- Throughput is one codeword per cycle when out_ready is held high.
- in_ready and out_valid are derived from registered pointers only. They have no combinational dependency on in_valid or out_ready.
- tx_count wraps from 255 to 0 on the next pop.
- If rst_n asserts mid-stream, buffered words are discarded and the reset values apply immediately. Outputs are valid from the first edge after deassertion.

## Configuration
- HAMMING_ERR_INJECT_EN
  - Defined: injection logic is compiled in and behaves as described above.
  - Undefined: the injection ports remain present but are unused. Stored words are always clean codewords and no injection logic is synthesized.

## Test plan
- Reset, then push 4'b1011 with out_ready=1: out_code=8'hAA and out_valid=1 for one cycle; push 4'h0 gives 8'h00, push 4'hF gives 8'hFF.
- Hold out_ready=0 and push 3 nibbles with FIFO_DEPTH=2: in_ready drops after the 2nd push and the 3rd is held. Release out_ready: all 3 words appear in order, tx_count=3.
- With FIFO full, assert out_ready and in_valid together: one pop and one push occur and occupancy stays 2.
- HAMMING_ERR_INJECT_EN defined:
  - Push 4'b1011 with inj_en=1, inj_pos_a=2: gives 8'hAE.
  - Add inj_double=1, inj_pos_b=5: gives 8'h8E.
  - pos_a = pos_b = 5 with inj_double=1: gives 8'hAA.
- Run 257 handshakes: tx_count reads 1 at the end. Assert rst_n low with 1 word buffered: out_valid=0 and tx_count=0 immediately.
- Random 1000 nibbles fed through the decoder model with injection off: zero error flags and data round-trips exactly.
